// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: clears the PE accumulators,
// drives skewed A/B feed enables, waits for the wavefront to drain, then steps a row readout.
module systolic_seq_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int TW = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 array_rst_n,
  output logic [TW-1:0]        feed_t,
  output logic [N-1:0]         a_lane_en,
  output logic [N-1:0]         b_lane_en,
  output logic                 res_valid,
  output logic [$clog2(N)-1:0] res_row
);

  localparam int RW  = $clog2(N);
  localparam int CW  = $clog2(N) + 1;
  localparam int TW1 = TW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ, S_DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k_reg;
  logic [CW-1:0] cnt;
  logic [TW-1:0] last_t;

  assign last_t = TW'(k_reg) + TW'(N - 2);

  // Lane i is live while its operand index k = t-i lies in [0, K).
  function automatic logic [N-1:0] lane_mask(input logic [TW-1:0] t, input logic [KW-1:0] k);
    logic [TW:0] lo;
    logic [TW:0] hi;
    lane_mask = '0;
    for (int i = 0; i < N; i++) begin
      lo = TW1'(i);
      hi = TW1'(k) + TW1'(i);
      lane_mask[i] = ({1'b0, t} >= lo) && ({1'b0, t} < hi);
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      k_reg       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_rst_n <= 1'b0;
      feed_t      <= '0;
      a_lane_en   <= '0;
      b_lane_en   <= '0;
      res_valid   <= 1'b0;
      res_row     <= '0;
    end else if (abort && state != S_IDLE) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_rst_n <= 1'b1;
      feed_t      <= '0;
      a_lane_en   <= '0;
      b_lane_en   <= '0;
      res_valid   <= 1'b0;
      res_row     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          array_rst_n <= 1'b1;
          done        <= 1'b0;
          if (start && !abort) begin
            k_reg       <= k_len;
            cnt         <= '0;
            busy        <= 1'b1;
            array_rst_n <= 1'b0;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (cnt == CW'(1)) begin
            array_rst_n <= 1'b1;
            cnt         <= '0;
            if (k_reg == '0) begin
              state     <= S_READ;
              res_valid <= 1'b1;
              res_row   <= '0;
            end else begin
              state     <= S_FEED;
              feed_t    <= '0;
              a_lane_en <= lane_mask('0, k_reg);
              b_lane_en <= lane_mask('0, k_reg);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FEED: begin
          if (feed_t == last_t) begin
            state     <= S_DRAIN;
            feed_t    <= '0;
            a_lane_en <= '0;
            b_lane_en <= '0;
            cnt       <= '0;
          end else begin
            feed_t    <= feed_t + TW'(1);
            a_lane_en <= lane_mask(feed_t + TW'(1), k_reg);
            b_lane_en <= lane_mask(feed_t + TW'(1), k_reg);
          end
        end
        S_DRAIN: begin
          // N-1 idle cycles let the last product reach PE(N-1,N-1).
          if (cnt == CW'(N - 2)) begin
            state     <= S_READ;
            res_valid <= 1'b1;
            res_row   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_READ: begin
          if (res_row == RW'(N - 1)) begin
            res_valid <= 1'b0;
            res_row   <= '0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            res_row <= res_row + RW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
